// File: rtl/cnt_sched_pkg.sv
// Shared FSM encodings and sizing helper for the cnt_sched counter scheduler.
// Optional cancel support is controlled by CNT_SCHED_CANCEL_EN in cnt_sched.sv.
package cnt_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Width of a requester index; never below one bit.
   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cnt_sched_rr.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
module cnt_sched_rr
   import cnt_sched_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned PW   = ptr_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] win_c,
   output logic [PW-1:0]   idx_c,
   output logic            any_c
);

   always_comb begin
      int unsigned slot;
      win_c = '0;
      idx_c = '0;
      any_c = 1'b0;
      slot  = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         slot = (32'(ptr) + k) % NREQ;
         if (!any_c && req[PW'(slot)]) begin
            any_c              = 1'b1;
            win_c[PW'(slot)]   = 1'b1;
            idx_c              = PW'(slot);
         end
      end
   end

endmodule

// File: rtl/cnt_sched.sv
// Shares one up-counter among NREQ requesters in round-robin order.
// Define CNT_SCHED_CANCEL_EN to add the per-requester cancel port.
module cnt_sched
   import cnt_sched_pkg::*;
#(
   parameter  int unsigned NREQ  = 4,
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned PW    = ptr_w(NREQ)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] top,
`ifdef CNT_SCHED_CANCEL_EN
   input  logic [NREQ-1:0]       cancel,
`endif
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic [PW-1:0]         owner,
   output logic [WIDTH-1:0]      cnt
);

   state_t             state, state_d;
   logic [NREQ-1:0]    gnt_d, done_d;
   logic               busy_d;
   logic [PW-1:0]      owner_d, ptr, ptr_d, next_ptr_c;
   logic [WIDTH-1:0]   cnt_d, top_l, top_l_d;
   logic [NREQ-1:0]    rr_win_c;
   logic [PW-1:0]      rr_idx_c;
   logic               rr_any_c;
   logic [WIDTH-1:0]   top_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_top
      assign top_a[i] = top[i*WIDTH +: WIDTH];
   end

   cnt_sched_rr #(.NREQ(NREQ)) u_rr (
      .req   (req),
      .ptr   (ptr),
      .win_c (rr_win_c),
      .idx_c (rr_idx_c),
      .any_c (rr_any_c)
   );

   // Pointer moves just past the owner once its job ends, giving it lowest priority.
   assign next_ptr_c = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

   always_comb begin
      state_d = state;
      gnt_d   = gnt;
      done_d  = '0;
      busy_d  = busy;
      owner_d = owner;
      cnt_d   = cnt;
      top_l_d = top_l;
      ptr_d   = ptr;
      case (state)
         S_IDLE: begin
            if (rr_any_c) begin
               owner_d = rr_idx_c;
               top_l_d = top_a[rr_idx_c];
               gnt_d   = rr_win_c;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Completion takes priority over a same-cycle cancel.
            if (cnt == top_l) begin
               done_d  = NREQ'(1) << owner;
               cnt_d   = '0;
               state_d = S_DONE;
            end
`ifdef CNT_SCHED_CANCEL_EN
            else if (cancel[owner]) begin
               gnt_d   = '0;
               busy_d  = 1'b0;
               cnt_d   = '0;
               ptr_d   = next_ptr_c;
               state_d = S_IDLE;
            end
`endif
            else begin
               cnt_d = cnt + WIDTH'(1);
            end
         end
         S_DONE: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            ptr_d   = next_ptr_c;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
         gnt   <= '0;
         done  <= '0;
         busy  <= 1'b0;
         owner <= '0;
         cnt   <= '0;
         top_l <= '0;
         ptr   <= '0;
      end else begin
         state <= state_d;
         gnt   <= gnt_d;
         done  <= done_d;
         busy  <= busy_d;
         owner <= owner_d;
         cnt   <= cnt_d;
         top_l <= top_l_d;
         ptr   <= ptr_d;
      end
   end

endmodule
